// File: rtl/bus_round_robin_arbiter.sv
// -----------------------------------------------------------------------------
// bus_round_robin_arbiter
//
// Purpose:
//   Round-robin arbiter for the shared single-master-at-a-time system bus
//   (begin/end transaction protocol). It grants the bus to one of NUM_MASTERS
//   requesters and tracks each transaction from its begin strobe to its
//   end/error strobe. After that strobe it releases the grant and rotates
//   priority past the master that just finished. It drives grant lines only;
//   no data is muxed here.
//
// Optional feature (compile-time macro BUS_ARB_WATCHDOG_EN):
//   When defined, a BUSY-cycle watchdog ends a hung transaction. On the timeout
//   it pulses bus_error_o and bus_endTransaction_o together for one cycle, then
//   releases the grant. When undefined, both outputs are tied low and a hung
//   transaction keeps the grant forever.
//
// Parameters:
//   NUM_MASTERS     number of requesters, 2..32
//   TIMEOUT_CYCLES  watchdog limit in clk_i cycles (watchdog build only), >= 2
//
// Ports:
//   clk_i                   in   system clock
//   rst_i                   in   synchronous, active-high reset
//   bus_request_i           in   per-master request level [NUM_MASTERS]
//   bus_grant_o             out  one-hot-or-zero grant, registered [NUM_MASTERS]
//   bus_beginTransaction_i  in   begin strobe from the granted master
//   bus_endTransaction_i    in   end strobe from slave or master
//   bus_error_i             in   error strobe from slaves (ends the transaction)
//   bus_endTransaction_o    out  watchdog-forced end strobe (OR'ed onto bus)
//   bus_error_o             out  watchdog-forced error strobe (OR'ed onto bus)
// -----------------------------------------------------------------------------
module bus_round_robin_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_MASTERS-1:0] bus_request_i,
  output logic [NUM_MASTERS-1:0] bus_grant_o,
  input  logic                   bus_beginTransaction_i,
  input  logic                   bus_endTransaction_i,
  input  logic                   bus_error_i,
  output logic                   bus_endTransaction_o,
  output logic                   bus_error_o
);

  // Reject out-of-range configurations at elaboration time.
  if ((NUM_MASTERS < 2) || (NUM_MASTERS > 32) || (TIMEOUT_CYCLES < 2)) begin : g_cfg_invalid
    $error("bus_round_robin_arbiter: NUM_MASTERS must be 2..32 and TIMEOUT_CYCLES >= 2");
  end

  localparam int PTR_W = $clog2(NUM_MASTERS);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_MASTERS - 1);
  localparam logic [PTR_W-1:0] ONE_IDX  = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_BUSY    = 2'd2
  } state_t;

  state_t                 state_r;
  logic [NUM_MASTERS-1:0] grant_r;
  logic [PTR_W-1:0]       ptr_r;       // highest-priority index for the next pick
  logic [PTR_W-1:0]       owner_r;     // index of the master currently granted
  logic                   pick_valid_s;
  logic [PTR_W-1:0]       pick_idx_s;
  logic                   wd_fire_s;   // watchdog pulse, acts as an end strobe
  logic                   end_s;       // any transaction-terminating event

  // Increment an index with an explicit wrap, so non-power-of-2 counts never
  // produce an out-of-range index.
  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
    logic [PTR_W-1:0] res;
    if (idx == LAST_IDX) begin
      res = '0;
    end else begin
      res = idx + ONE_IDX;
    end
    return res;
  endfunction

  // Convert an index into a one-hot grant vector.
  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_MASTERS-1:0] res;
    res      = '0;
    res[idx] = 1'b1;
    return res;
  endfunction

  // Round-robin pick: first requester at an index >= ptr_r, wrapping once.
  always_comb begin
    logic [PTR_W-1:0] idx_v;
    pick_valid_s = 1'b0;
    pick_idx_s   = ptr_r;
    idx_v        = ptr_r;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!pick_valid_s && bus_request_i[idx_v]) begin
        pick_valid_s = 1'b1;
        pick_idx_s   = idx_v;
      end else begin
        pick_valid_s = pick_valid_s;
      end
      idx_v = next_idx(idx_v);
    end
  end

`ifdef BUS_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] wd_cnt_r;
  logic             wd_pulse_r;

  // Watchdog: count BUSY cycles. If the limit cycle passes with no genuine
  // end/error, raise a single-cycle pulse. The pulse cycle is still BUSY, and
  // the FSM treats the pulse as the end strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt_r   <= '0;
      wd_pulse_r <= 1'b0;
    end else if ((state_r == ST_GRANTED) && bus_beginTransaction_i) begin
      wd_cnt_r   <= '0;
      wd_pulse_r <= 1'b0;
    end else if ((state_r == ST_BUSY) && !wd_pulse_r &&
                 !bus_endTransaction_i && !bus_error_i) begin
      if (wd_cnt_r == CNT_LIMIT) begin
        wd_pulse_r <= 1'b1;
      end else begin
        wd_cnt_r <= wd_cnt_r + CNT_ONE;
      end
    end else begin
      wd_pulse_r <= 1'b0;
    end
  end

  assign wd_fire_s            = wd_pulse_r;
  assign bus_error_o          = wd_pulse_r;
  assign bus_endTransaction_o = wd_pulse_r;
`else
  assign wd_fire_s            = 1'b0;
  assign bus_error_o          = 1'b0;
  assign bus_endTransaction_o = 1'b0;
`endif

  assign end_s = bus_endTransaction_i | bus_error_i | wd_fire_s;

  // Arbitration FSM with registered grant. Stray end/error strobes are ignored
  // outside BUSY, and begin strobes are ignored outside GRANTED.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      grant_r <= '0;
      ptr_r   <= '0;
      owner_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            grant_r <= onehot(pick_idx_s);
            owner_r <= pick_idx_s;
            state_r <= ST_GRANTED;
          end else begin
            grant_r <= '0;
          end
        end
        ST_GRANTED: begin
          // Begin wins over a simultaneous request drop.
          if (bus_beginTransaction_i) begin
            state_r <= ST_BUSY;
          end else if (!bus_request_i[owner_r]) begin
            // Abandoned grant: priority is not rotated.
            grant_r <= '0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_GRANTED;
          end
        end
        ST_BUSY: begin
          if (end_s) begin
            grant_r <= '0;
            ptr_r   <= next_idx(owner_r);
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        default: begin
          grant_r <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_grant_o = grant_r;

endmodule

// File: tb/tb_bus_round_robin_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_round_robin_arbiter
//
// Purpose:
//   Directed-vector bench for bus_round_robin_arbiter (NUM_MASTERS=4,
//   TIMEOUT_CYCLES=16). Expected values are computed by hand. It covers reset,
//   round-robin rotation, abandoned grants, error termination, stray strobes,
//   the hung-transaction behaviour of the current build, and reset during a
//   transaction.
// -----------------------------------------------------------------------------
module tb_bus_round_robin_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic       begin_i;
  logic       end_i;
  logic       err_i;
  logic       end_o;
  logic       err_o;

  int total_cnt;
  int bad_cnt;

  bus_round_robin_arbiter #(
    .NUM_MASTERS   (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .bus_request_i         (req),
    .bus_grant_o           (grant),
    .bus_beginTransaction_i(begin_i),
    .bus_endTransaction_i  (end_i),
    .bus_error_i           (err_i),
    .bus_endTransaction_o  (end_o),
    .bus_error_o           (err_o)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL time_limit: run did not reach its end, total=%0d", total_cnt);
    $fatal(1, "time limit");
  end

  // Count one comparison and report it if it mismatches.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting from IDLE with requests applied: grant, begin, hold 5 cycles,
  // end, then confirm the turnaround cycle has no grant.
  task automatic run_txn(input string tag, input logic [3:0] exp);
    tick();
    check_val({tag, "_grant"}, {28'd0, grant}, {28'd0, exp});
    begin_i = 1'b1;
    tick();
    begin_i = 1'b0;
    repeat (4) tick();
    check_val({tag, "_busy"}, {28'd0, grant}, {28'd0, exp});
    end_i = 1'b1;
    tick();
    end_i = 1'b0;
    check_val({tag, "_gap"}, {28'd0, grant}, 32'd0);
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst       = 1'b1;
    req       = 4'b1111;
    begin_i   = 1'b0;
    end_i     = 1'b0;
    err_i     = 1'b0;

    // 1: reset held with all requests -> nothing granted, no strobes.
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("rst_grant", {28'd0, grant}, 32'd0);
      check_val("rst_err_o", {31'd0, err_o}, 32'd0);
      check_val("rst_end_o", {31'd0, end_o}, 32'd0);
    end
    rst = 1'b0;

    // 2: round robin with all requesting, pointer ends at 1.
    run_txn("rr0", 4'b0001);
    run_txn("rr1", 4'b0010);
    run_txn("rr2", 4'b0100);
    run_txn("rr3", 4'b1000);
    run_txn("rr4", 4'b0001);

    // 3: move pointer to 2, then abandon master 2's grant.
    req = 4'b0010;
    run_txn("ptr_to2", 4'b0010);
    req = 4'b0100;
    tick();
    check_val("ab_grant", {28'd0, grant}, 32'h4);
    req = 4'b0000;
    tick();
    check_val("ab_drop", {28'd0, grant}, 32'h0);
    req = 4'b0110;
    tick();
    check_val("ab_ptr_kept", {28'd0, grant}, 32'h4);
    // Request drop together with begin: begin wins.
    req     = 4'b0000;
    begin_i = 1'b1;
    tick();
    begin_i = 1'b0;
    check_val("begin_wins", {28'd0, grant}, 32'h4);
    end_i = 1'b1;
    tick();
    end_i = 1'b0;
    check_val("end_m2", {28'd0, grant}, 32'h0);

    // Stray end in IDLE and GRANTED is ignored; pointer 3 wraps to pick 1.
    req   = 4'b0010;
    end_i = 1'b1;
    tick();
    check_val("stray_idle", {28'd0, grant}, 32'h2);
    tick();
    check_val("stray_granted", {28'd0, grant}, 32'h2);
    end_i   = 1'b0;
    begin_i = 1'b1;
    tick();
    begin_i = 1'b0;
    // Request level is ignored while BUSY.
    req = 4'b0000;
    tick();
    check_val("busy_req_ign", {28'd0, grant}, 32'h2);

    // 4: error ends master 1's transaction, pointer 2 wraps to master 0.
    err_i = 1'b1;
    tick();
    err_i = 1'b0;
    check_val("err_end", {28'd0, grant}, 32'h0);
    req = 4'b0011;
    tick();
    check_val("err_ptr_wrap", {28'd0, grant}, 32'h1);
    begin_i = 1'b1;
    tick();
    begin_i = 1'b0;
    end_i   = 1'b1;
    tick();
    end_i = 1'b0;
    check_val("m0_end", {28'd0, grant}, 32'h0);

    // 5: hung transaction on master 0 (pointer 1 wraps to 0).
    req = 4'b0001;
    tick();
    check_val("hang_grant", {28'd0, grant}, 32'h1);
    begin_i = 1'b1;
    tick();
    begin_i = 1'b0;
`ifdef BUS_ARB_WATCHDOG_EN
    for (int i = 1; i < 16; i++) begin
      tick();
      check_val("wd_quiet_err", {31'd0, err_o}, 32'd0);
      check_val("wd_quiet_grant", {28'd0, grant}, 32'h1);
    end
    tick();
    check_val("wd_pulse_err", {31'd0, err_o}, 32'd1);
    check_val("wd_pulse_end", {31'd0, end_o}, 32'd1);
    check_val("wd_pulse_grant", {28'd0, grant}, 32'h1);
    tick();
    check_val("wd_after_err", {31'd0, err_o}, 32'd0);
    check_val("wd_after_end", {31'd0, end_o}, 32'd0);
    check_val("wd_after_grant", {28'd0, grant}, 32'h0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      check_val("hang_grant_held", {28'd0, grant}, 32'h1);
      check_val("hang_err_o", {31'd0, err_o}, 32'd0);
      check_val("hang_end_o", {31'd0, end_o}, 32'd0);
    end
    end_i = 1'b1;
    tick();
    end_i = 1'b0;
    check_val("hang_end", {28'd0, grant}, 32'h0);
`endif

    // 6: reset during BUSY of master 2 (pointer is 1, so 0100 is picked).
    req = 4'b0100;
    tick();
    check_val("mid_grant", {28'd0, grant}, 32'h4);
    begin_i = 1'b1;
    tick();
    begin_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    req = 4'b1111;
    tick();
    check_val("mid_rst_grant", {28'd0, grant}, 32'h0);
    check_val("mid_rst_err_o", {31'd0, err_o}, 32'd0);
    check_val("mid_rst_end_o", {31'd0, end_o}, 32'd0);
    rst = 1'b0;
    tick();
    check_val("mid_rst_ptr0", {28'd0, grant}, 32'h1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
